// File: rtl/issue_rat_freelist_fifo.sv
// Circular free list of PRF indices feeding rename and the free-list checkpoint.
// Optional same-cycle push-to-allocate forwarding when empty: define ISSUE_RAT_FREELIST_BYPASS_EN.
module issue_rat_freelist_fifo #(
  parameter int PRF_WIDTH  = 6,
  parameter int FGR_WIDTH  = 4,
  parameter int ARCH_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_alloc_valid,
  input  logic [FGR_WIDTH-1:0] i_alloc_fgr,
  output logic                 o_alloc_ready,
  output logic [PRF_WIDTH-1:0] o_alloc_prf,
  output logic                 o_acquired_valid,
  input  logic                 i_acquired_ready,
  output logic [FGR_WIDTH-1:0] o_acquired_fgr,
  output logic [PRF_WIDTH-1:0] o_acquired_prf,
  input  logic                 i_abandoned_valid,
  output logic                 o_abandoned_ready,
  input  logic [PRF_WIDTH-1:0] i_abandoned_prf,
  input  logic                 i_release_valid,
  input  logic [PRF_WIDTH-1:0] i_release_prf,
  output logic                 o_init_done,
  output logic                 o_overflow
);

  localparam int PRF_COUNT = 1 << PRF_WIDTH;
  localparam int CNT_WIDTH = PRF_WIDTH + 1;
  localparam int SPC_WIDTH = PRF_WIDTH + 2;
  localparam logic [PRF_WIDTH-1:0] INIT_LAST = PRF_WIDTH'(PRF_COUNT - ARCH_COUNT - 1);
  localparam logic [PRF_WIDTH-1:0] ARCH_BASE = PRF_WIDTH'(ARCH_COUNT);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [PRF_WIDTH-1:0] head_q, head_d;
  logic [PRF_WIDTH-1:0] tail_q, tail_d;
  logic [PRF_WIDTH-1:0] init_k_q, init_k_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [PRF_WIDTH-1:0] mem_q [PRF_COUNT];

  logic                 run;
  logic                 empty;
  logic                 push_ab_req;
  logic                 push_rel_req;
  logic                 fwd_active;
  logic                 acq_valid;
  logic [PRF_WIDTH-1:0] acq_prf;
  logic                 fire;
  logic [SPC_WIDTH-1:0] space;
  logic                 accept_ab;
  logic                 accept_rel;
  logic                 drop;
  logic [CNT_WIDTH-1:0] n_push;

  logic                 wr0_en;
  logic [PRF_WIDTH-1:0] wr0_addr;
  logic [PRF_WIDTH-1:0] wr0_data;
  logic                 wr1_en;
  logic [PRF_WIDTH-1:0] wr1_addr;
  logic [PRF_WIDTH-1:0] wr1_data;

  always_comb begin
    run          = (state_q == ST_RUN);
    empty        = (count_q == '0);
    push_ab_req  = run & i_abandoned_valid;
    push_rel_req = run & i_release_valid;
`ifdef ISSUE_RAT_FREELIST_BYPASS_EN
    fwd_active   = empty & (push_ab_req | push_rel_req);
`else
    fwd_active   = 1'b0;
`endif
    acq_valid    = run & i_alloc_valid & (~empty | fwd_active);
    acq_prf      = fwd_active ? (push_ab_req ? i_abandoned_prf : i_release_prf)
                              : mem_q[head_q];
    fire         = acq_valid & i_acquired_ready;
    // A same-cycle pop frees a slot, so capacity is judged on the net count.
    space        = SPC_WIDTH'(PRF_COUNT) - SPC_WIDTH'(count_q) + SPC_WIDTH'(fire);
    accept_ab    = push_ab_req & (space >= SPC_WIDTH'(1));
    accept_rel   = push_rel_req & (space >= (SPC_WIDTH'(1) + SPC_WIDTH'(accept_ab)));
    drop         = (push_ab_req & ~accept_ab) | (push_rel_req & ~accept_rel);
    n_push       = CNT_WIDTH'(accept_ab) + CNT_WIDTH'(accept_rel);
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    init_k_d   = init_k_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr0_en     = 1'b0;
    wr0_addr   = tail_q;
    wr0_data   = i_abandoned_prf;
    wr1_en     = 1'b0;
    wr1_addr   = tail_q;
    wr1_data   = i_release_prf;
    if (state_q == ST_INIT) begin
      wr0_en   = 1'b1;
      wr0_data = ARCH_BASE + init_k_q;
      tail_d   = tail_q + PRF_WIDTH'(1);
      count_d  = count_q + CNT_WIDTH'(1);
      init_k_d = init_k_q + PRF_WIDTH'(1);
      if (init_k_q == INIT_LAST) begin
        state_d = ST_RUN;
      end
    end else begin
      // A forwarded PRF occupies its tail slot logically but is never stored.
      wr0_en     = accept_ab & ~(fire & fwd_active);
      wr1_en     = accept_rel & ~(fire & fwd_active & ~push_ab_req);
      wr1_addr   = tail_q + PRF_WIDTH'(accept_ab);
      head_d     = head_q + PRF_WIDTH'(fire);
      tail_d     = tail_q + PRF_WIDTH'(n_push);
      count_d    = count_q + n_push - CNT_WIDTH'(fire);
      overflow_d = overflow_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      head_q     <= '0;
      tail_q     <= '0;
      init_k_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_k_q   <= init_k_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr0_en) begin
        mem_q[wr0_addr] <= wr0_data;
      end
      if (wr1_en) begin
        mem_q[wr1_addr] <= wr1_data;
      end
    end
  end

  assign o_acquired_valid  = acq_valid;
  assign o_alloc_ready     = fire;
  assign o_alloc_prf       = acq_prf;
  assign o_acquired_prf    = acq_prf;
  assign o_acquired_fgr    = i_alloc_fgr;
  assign o_abandoned_ready = run;
  assign o_init_done       = run;
  assign o_overflow        = overflow_q;

endmodule

// File: tb/tb_issue_rat_freelist_fifo.sv
// Self-checking bench for issue_rat_freelist_fifo: queue-based free-list model,
// directed scenarios plus randomized traffic; honours ISSUE_RAT_FREELIST_BYPASS_EN.
module tb_issue_rat_freelist_fifo;

  localparam int PRF_COUNT  = 64;
  localparam int ARCH_COUNT = 32;
  localparam int FREE_COUNT = PRF_COUNT - ARCH_COUNT;
`ifdef ISSUE_RAT_FREELIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_alloc_valid;
  logic [3:0] i_alloc_fgr;
  logic       o_alloc_ready;
  logic [5:0] o_alloc_prf;
  logic       o_acquired_valid;
  logic       i_acquired_ready;
  logic [3:0] o_acquired_fgr;
  logic [5:0] o_acquired_prf;
  logic       i_abandoned_valid;
  logic       o_abandoned_ready;
  logic [5:0] i_abandoned_prf;
  logic       i_release_valid;
  logic [5:0] i_release_prf;
  logic       o_init_done;
  logic       o_overflow;

  issue_rat_freelist_fifo dut (
    .clk              (clk),
    .reset            (reset),
    .i_alloc_valid    (i_alloc_valid),
    .i_alloc_fgr      (i_alloc_fgr),
    .o_alloc_ready    (o_alloc_ready),
    .o_alloc_prf      (o_alloc_prf),
    .o_acquired_valid (o_acquired_valid),
    .i_acquired_ready (i_acquired_ready),
    .o_acquired_fgr   (o_acquired_fgr),
    .o_acquired_prf   (o_acquired_prf),
    .i_abandoned_valid(i_abandoned_valid),
    .o_abandoned_ready(o_abandoned_ready),
    .i_abandoned_prf  (i_abandoned_prf),
    .i_release_valid  (i_release_valid),
    .i_release_prf    (i_release_prf),
    .o_init_done      (o_init_done),
    .o_overflow       (o_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the free list is simply an ordered queue of PRF numbers.
  int q[$];
  bit mdl_known = 1'b0;
  bit mdl_run   = 1'b0;
  int mdl_k     = 0;
  bit mdl_ovf   = 1'b0;

  int snap_valid, snap_ready, snap_prf, snap_fgr, snap_init_done, snap_ovf;

  task automatic cmp(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic check_output();
    bit ev;
    int ep;
    snap_valid     = int'(o_acquired_valid);
    snap_ready     = int'(o_alloc_ready);
    snap_prf       = int'(o_acquired_prf);
    snap_fgr       = int'(o_acquired_fgr);
    snap_init_done = int'(o_init_done);
    snap_ovf       = int'(o_overflow);
    if (!mdl_known) return;
    if (!mdl_run) begin
      cmp("init_acq_valid", int'(o_acquired_valid), 0);
      cmp("init_alloc_ready", int'(o_alloc_ready), 0);
      cmp("init_abandoned_ready", int'(o_abandoned_ready), 0);
      cmp("init_done_low", int'(o_init_done), 0);
      cmp("init_overflow", int'(o_overflow), int'(mdl_ovf));
    end else begin
      ev = i_alloc_valid && (q.size() > 0 || (BYP && (i_abandoned_valid || i_release_valid)));
      if (q.size() > 0) ep = q[0];
      else ep = i_abandoned_valid ? int'(i_abandoned_prf) : int'(i_release_prf);
      cmp("acq_valid", int'(o_acquired_valid), int'(ev));
      cmp("alloc_ready", int'(o_alloc_ready), int'(ev && i_acquired_ready));
      cmp("abandoned_ready", int'(o_abandoned_ready), 1);
      cmp("init_done_high", int'(o_init_done), 1);
      cmp("overflow", int'(o_overflow), int'(mdl_ovf));
      if (ev) begin
        cmp("alloc_prf", int'(o_alloc_prf), ep);
        cmp("acquired_prf", int'(o_acquired_prf), ep);
        cmp("acquired_fgr", int'(o_acquired_fgr), int'(i_alloc_fgr));
      end
    end
  endtask

  task automatic update_model();
    bit fire;
    bit fwd_used;
    if (reset) begin
      q.delete();
      mdl_known = 1'b1;
      mdl_run   = 1'b0;
      mdl_k     = 0;
      mdl_ovf   = 1'b0;
      return;
    end
    if (!mdl_known) return;
    if (!mdl_run) begin
      q.push_back(ARCH_COUNT + mdl_k);
      mdl_k++;
      if (mdl_k == FREE_COUNT) mdl_run = 1'b1;
      return;
    end
    fire     = i_alloc_valid && i_acquired_ready &&
               (q.size() > 0 || (BYP && (i_abandoned_valid || i_release_valid)));
    fwd_used = fire && (q.size() == 0);
    if (fire && q.size() > 0) void'(q.pop_front());
    if (i_abandoned_valid) begin
      if (!fwd_used) begin
        if (q.size() < PRF_COUNT) q.push_back(int'(i_abandoned_prf));
        else mdl_ovf = 1'b1;
      end
    end
    if (i_release_valid) begin
      if (!(fwd_used && !i_abandoned_valid)) begin
        if (q.size() < PRF_COUNT) q.push_back(int'(i_release_prf));
        else mdl_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit av, input logic [3:0] fgr, input bit ar,
                      input bit abv, input logic [5:0] abp, input bit rlv, input logic [5:0] rlp);
    reset             = rst;
    i_alloc_valid     = av;
    i_alloc_fgr       = fgr;
    i_acquired_ready  = ar;
    i_abandoned_valid = abv;
    i_abandoned_prf   = abp;
    i_release_valid   = rlv;
    i_release_prf     = rlp;
    @(negedge clk);
    check_output();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 0, 6'd0, 0, 6'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset and initialisation timing.
    step(1, 0, 4'd0, 0, 0, 6'd0, 0, 6'd0);
    idle(FREE_COUNT);
    cmp("init_done_before_32", snap_init_done, 0);
    cmp("model_count_after_init", q.size(), 32);

    step(0, 1, 4'd3, 1, 0, 6'd0, 0, 6'd0);
    cmp("init_done_at_32", snap_init_done, 1);
    cmp("first_alloc_32", snap_prf, 32);
    step(0, 1, 4'd3, 1, 0, 6'd0, 0, 6'd0);
    cmp("second_alloc_33", snap_prf, 33);
    for (int i = 0; i < 30; i++) step(0, 1, 4'd3, 1, 0, 6'd0, 0, 6'd0);
    cmp("last_alloc_63", snap_prf, 63);
    cmp("last_alloc_fgr", snap_fgr, 3);
    step(0, 1, 4'd3, 1, 0, 6'd0, 0, 6'd0);
    cmp("empty_blocks_alloc", snap_valid, 0);

    // Two pushes into an empty list in the same cycle.
    step(0, 1, 4'd5, 1, 1, 6'd40, 1, 6'd45);
    cmp("empty_push_valid", snap_valid, int'(BYP));
    cmp("count_after_double_push", q.size(), BYP ? 1 : 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'd5, 0, 0, 6'd0, 0, 6'd0);
      cmp("hold_no_fire", snap_ready, 0);
      cmp("hold_prf_stable", snap_prf, BYP ? 45 : 40);
    end
    step(0, 1, 4'd5, 1, 0, 6'd0, 0, 6'd0);
    cmp("release_hold_prf", snap_prf, BYP ? 45 : 40);
`ifndef ISSUE_RAT_FREELIST_BYPASS_EN
    step(0, 1, 4'd5, 1, 0, 6'd0, 0, 6'd0);
    cmp("second_pushed_prf_45", snap_prf, 45);
`endif

    // Fill to 64 entries, then force one more release.
    for (int i = 0; i < PRF_COUNT; i++) step(0, 0, 4'd0, 0, 0, 6'd0, 1, 6'(i));
    cmp("model_full", q.size(), 64);
    step(0, 0, 4'd0, 0, 0, 6'd0, 1, 6'd7);
    step(0, 0, 4'd0, 0, 0, 6'd0, 0, 6'd0);
    cmp("overflow_set", snap_ovf, 1);
    cmp("count_stays_64", q.size(), 64);
    idle(3);
    cmp("overflow_sticky", snap_ovf, 1);
    step(0, 1, 4'd1, 1, 0, 6'd0, 0, 6'd0);
    cmp("full_head_prf_0", snap_prf, 0);

    // Randomized traffic: first near empty, then push-heavy to reach full.
    for (int i = 0; i < 800; i++)
      step(0, $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, 6'($urandom), $urandom_range(0, 3) == 0, 6'($urandom));
    for (int i = 0; i < 500; i++)
      step(0, $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, 6'($urandom), $urandom_range(0, 1) != 0, 6'($urandom));

    // Reset mid-stream after 10 allocations.
    step(1, 0, 4'd0, 0, 0, 6'd0, 0, 6'd0);
    idle(FREE_COUNT);
    for (int i = 0; i < 10; i++) step(0, 1, 4'd2, 1, 0, 6'd0, 0, 6'd0);
    cmp("tenth_alloc_41", snap_prf, 41);
    step(1, 1, 4'd2, 1, 0, 6'd0, 0, 6'd0);
    idle(FREE_COUNT);
    step(0, 1, 4'd9, 1, 0, 6'd0, 0, 6'd0);
    cmp("reset_realloc_32", snap_prf, 32);
    cmp("reset_overflow_clear", snap_ovf, 0);
    cmp("reset_init_done", snap_init_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
